// File: rtl/sha_msg_sched_pkg.sv
// Shared widths, FSM states and the SHA-256 small-sigma functions used by
// the message schedule expander.
package sha_msg_sched_pkg;

    localparam int WORD_S      = 32;
    localparam int BLK_WORDS   = 16;
    localparam int SCHED_WORDS = 64;
    localparam int W_BLKCNT    = SCHED_WORDS / 2;
    localparam int BLK_S       = BLK_WORDS * WORD_S;
    localparam int WARR_S      = W_BLKCNT * WORD_S;
    localparam int IDX_W       = $clog2(SCHED_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } sched_state_e;

    function automatic logic [WORD_S-1:0] sig0(input logic [WORD_S-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_S-1:0] sig1(input logic [WORD_S-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha_sched_word.sv
// One step of the SHA-256 schedule recurrence:
// W[t] = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16], mod 2^32.
module sha_sched_word
    import sha_msg_sched_pkg::*;
(
    input  logic [WORD_S-1:0] w2,
    input  logic [WORD_S-1:0] w7,
    input  logic [WORD_S-1:0] w15,
    input  logic [WORD_S-1:0] w16,
    output logic [WORD_S-1:0] word
);

    // Sum is kept at word width so the carry out is simply dropped.
    assign word = sig1(w2) + w7 + sig0(w15) + w16;

endmodule

// File: rtl/sha_msg_sched.sv
// Expands a 512-bit padded block into the 64-word SHA-256 schedule, one word
// per cycle, exposing W[0..31] early via lo_valid and all words via out_valid.
module sha_msg_sched
    import sha_msg_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BLK_S-1:0]  blk_in,
    input  logic              blk_valid,
    output logic              blk_ready,
    output logic [WARR_S-1:0] w_lo,
    output logic [WARR_S-1:0] w_hi,
    output logic              lo_valid,
    output logic              out_valid,
    input  logic              out_ready
);

    sched_state_e       state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic               lo_valid_r;
    logic [WORD_S-1:0]  w_mem [SCHED_WORDS];
    logic [WORD_S-1:0]  new_word;

    sha_sched_word u_word (
        .w2   (w_mem[idx - IDX_W'(2)]),
        .w7   (w_mem[idx - IDX_W'(7)]),
        .w15  (w_mem[idx - IDX_W'(15)]),
        .w16  (w_mem[idx - IDX_W'(16)]),
        .word (new_word)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (blk_valid) state_nxt = ST_EXPAND;
            ST_EXPAND: if (idx == IDX_W'(SCHED_WORDS - 1)) state_nxt = ST_DONE;
            ST_DONE:   if (out_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            lo_valid_r <= 1'b0;
            for (int i = 0; i < SCHED_WORDS; i++) w_mem[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (blk_valid) begin
                        // Upper words are zeroed so stale data from the previous
                        // block never shows through before being rewritten.
                        for (int i = 0; i < SCHED_WORDS; i++)
                            w_mem[i] <= (i < BLK_WORDS) ? blk_in[i*WORD_S +: WORD_S] : '0;
                        idx <= IDX_W'(BLK_WORDS);
                    end
                end
                ST_EXPAND: begin
                    w_mem[idx] <= new_word;
                    idx        <= idx + IDX_W'(1);
                    if (idx == IDX_W'(W_BLKCNT - 1)) lo_valid_r <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) lo_valid_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign blk_ready = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign lo_valid  = lo_valid_r;

    for (genvar g = 0; g < W_BLKCNT; g++) begin : g_out
        assign w_lo[g*WORD_S +: WORD_S] = w_mem[g];
        assign w_hi[g*WORD_S +: WORD_S] = w_mem[W_BLKCNT + g];
    end

endmodule

// File: tb/tb_sha_msg_sched.sv
// Randomised bench for sha_msg_sched with a cycle-level reference model and a
// standalone check of the sha_sched_word recurrence step.
module tb_sha_msg_sched;
    import sha_msg_sched_pkg::*;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [511:0]   blk_in = '0;
    logic           blk_valid = 1'b0;
    logic           blk_ready;
    logic [1023:0]  w_lo, w_hi;
    logic           lo_valid, out_valid;
    logic           out_ready = 1'b0;

    logic [31:0] u_w2 = '0, u_w7 = '0, u_w15 = '0, u_w16 = '0, u_word;

    always #5 clk = ~clk;

    sha_msg_sched dut (
        .clk       (clk),
        .reset     (reset),
        .blk_in    (blk_in),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .w_lo      (w_lo),
        .w_hi      (w_hi),
        .lo_valid  (lo_valid),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    sha_sched_word u_sw (
        .w2   (u_w2),
        .w7   (u_w7),
        .w15  (u_w15),
        .w16  (u_w16),
        .word (u_word)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a, b, c, d);
        logic [31:0] s0, s1;
        logic [63:0] s;
        s1 = m_rotr(a, 17) ^ m_rotr(a, 19) ^ (a >> 10);
        s0 = m_rotr(c, 7) ^ m_rotr(c, 18) ^ (c >> 3);
        s = {32'd0, s1} + {32'd0, b} + {32'd0, s0} + {32'd0, d};
        return s[31:0];
    endfunction

    function automatic logic [31:0] m_wordat(input logic [511:0] b, input int n);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = b[i*32 +: 32];
        for (int i = 16; i < 64; i++) w[i] = m_word(w[i-2], w[i-7], w[i-15], w[i-16]);
        return w[n];
    endfunction

    logic [31:0] m_sched [64];
    bit          m_run;
    int          m_k;

    initial begin
        m_run = 0;
        m_k = 48;
        for (int i = 0; i < 64; i++) m_sched[i] = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_run = 0;
                m_k = 48;
                for (int i = 0; i < 64; i++) m_sched[i] = '0;
            end else begin
                cyc++;
                if (!m_run) begin
                    if (blk_valid) begin
                        for (int i = 0; i < 64; i++) m_sched[i] = m_wordat(blk_in, i);
                        m_run = 1;
                        m_k = 0;
                    end
                end else if (m_k < 48) begin
                    m_k++;
                end else if (out_ready) begin
                    m_run = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare + event monitor ----------------
    int dut_acc_cyc = 0, dut_acc_prev = 0, dut_acc_n = 0;
    int lo_rise_cyc = 0, out_rise_cyc = 0;

    initial begin
        logic        rdy_q, lo_q, out_q;
        logic [31:0] ew, aw, bad_e, bad_a;
        int          bad;
        rdy_q = 1'b1; lo_q = 1'b0; out_q = 1'b0;
        forever begin
            @(negedge clk);
            chk("blk_ready", blk_ready, !m_run);
            chk("lo_valid", lo_valid, m_run && m_k >= 16);
            chk("out_valid", out_valid, m_run && m_k == 48);
            bad = -1; bad_e = '0; bad_a = '0;
            for (int i = 0; i < 64; i++) begin
                ew = (i < 16 + m_k) ? m_sched[i] : 32'd0;
                aw = (i < 32) ? w_lo[i*32 +: 32] : w_hi[(i-32)*32 +: 32];
                if (aw !== ew && bad < 0) begin
                    bad = i; bad_e = ew; bad_a = aw;
                end
            end
            checks++;
            if (bad >= 0) begin
                failures++;
                $display("FAIL w_bus word %0d got=%h want=%h (cycle %0d)", bad, bad_a, bad_e, cyc);
            end
            if (rdy_q && !blk_ready && !reset) begin
                dut_acc_prev = dut_acc_cyc;
                dut_acc_cyc = cyc;
                dut_acc_n++;
            end
            if (!lo_q && lo_valid) lo_rise_cyc = cyc;
            if (!out_q && out_valid) out_rise_cyc = cyc;
            rdy_q = blk_ready; lo_q = lo_valid; out_q = out_valid;
        end
    end

    task automatic wait_out(input string nm);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_out_timeout"}, out_valid, 1'b1);
    endtask

    task automatic wait_acc(input string nm, input int n0);
        int n = 0;
        while (dut_acc_n == n0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dut_acc_n == n0) begin
            failures++;
            $display("FAIL %s accept_timeout got=none want=accept", nm);
        end
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [511:0]  abc;
        logic [1023:0] snap_lo, snap_hi;
        int            hs_cyc, n0;

        // Recurrence step in isolation
        u_w2 = '1; u_w7 = '1; u_w15 = '1; u_w16 = '1;
        #1;
        chk("sw_all_ones", u_word, 32'h203ffffc);
        for (int v = 0; v < 10000; v++) begin
            u_w2 = $urandom; u_w7 = $urandom; u_w15 = $urandom; u_w16 = $urandom;
            #1;
            chk("sw_rand", u_word, m_word(u_w2, u_w7, u_w15, u_w16));
        end

        // Reset state and model pins
        abc = '0;
        abc[31:0] = 32'h61626380;
        abc[511:480] = 32'h00000018;
        chk("model_abc_w16", m_wordat(abc, 16), 32'h61626380);
        chk("model_abc_w17", m_wordat(abc, 17), 32'h000f0000);
        chk("rst_blk_ready", blk_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_lo_valid", lo_valid, 1'b0);
        chk("rst_w_zero", (w_lo == '0 && w_hi == '0), 1'b1);

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // "abc" block
        n0 = dut_acc_n;
        blk_in = abc;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        wait_acc("abc", n0);
        wait_out("abc");
        chk("abc_out_latency", out_rise_cyc - dut_acc_cyc, 48);
        chk("abc_lo_latency", lo_rise_cyc - dut_acc_cyc, 16);
        chk("abc_w16", w_lo[16*32 +: 32], 32'h61626380);
        chk("abc_w17", w_lo[17*32 +: 32], 32'h000f0000);

        // Hold DONE with a pending all-zero block
        snap_lo = w_lo; snap_hi = w_hi;
        n0 = dut_acc_n;
        blk_in = '0;
        blk_valid = 1'b1;
        repeat (20) @(negedge clk);
        chk("hold_w_lo", w_lo == snap_lo, 1'b1);
        chk("hold_w_hi", w_hi == snap_hi, 1'b1);
        chk("hold_blk_ready", blk_ready, 1'b0);
        chk("hold_out_valid", out_valid, 1'b1);
        chk("hold_no_accept", dut_acc_n, n0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        hs_cyc = cyc;
        chk("hs_out_valid", out_valid, 1'b0);
        chk("hs_lo_valid", lo_valid, 1'b0);
        @(negedge clk);
        blk_valid = 1'b0;
        chk("pend_accepted", dut_acc_n, n0 + 1);
        chk("pend_accept_cycle", dut_acc_cyc, hs_cyc + 1);
        wait_out("zero");
        chk("zero_out_latency", out_rise_cyc - dut_acc_cyc, 48);
        chk("zero_lo_latency", lo_rise_cyc - dut_acc_cyc, 16);
        chk("zero_w63", w_hi[31*32 +: 32], 32'd0);

        // Back-to-back random blocks
        out_ready = 1'b1;
        @(negedge clk);
        n0 = dut_acc_n;
        blk_in = rand_blk();
        blk_valid = 1'b1;
        wait_acc("b2b_first", n0);
        blk_in = rand_blk();
        n0 = dut_acc_n;
        wait_acc("b2b_second", n0);
        blk_valid = 1'b0;
        chk("b2b_gap", dut_acc_cyc - dut_acc_prev, 50);
        wait_out("b2b");
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset while idx == 30
        n0 = dut_acc_n;
        blk_in = rand_blk();
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        wait_acc("abort", n0);
        repeat (14) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_w_lo_zero", w_lo == '0, 1'b1);
        chk("abort_w_hi_zero", w_hi == '0, 1'b1);
        chk("abort_lo_valid", lo_valid, 1'b0);
        chk("abort_out_valid", out_valid, 1'b0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_blk_ready", blk_ready, 1'b1);
        n0 = dut_acc_n;
        blk_in = rand_blk();
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        wait_acc("post_abort", n0);
        wait_out("post_abort");
        chk("post_abort_latency", out_rise_cyc - dut_acc_cyc, 48);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
